// File: rtl/debug_autobaud_pkg.sv
// -----------------------------------------------------------------------------
// debug_autobaud_pkg
// Shared constants for the debug UART auto-baud logic:
//   - 3-bit FSM state encoding
//   - power-on divider for the debug baud generator
//   - number of quiet high clocks required before a sync byte is accepted
//   - rounding constant and shift for the divider calculation
// -----------------------------------------------------------------------------
package debug_autobaud_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_IDLE  = 3'd1;
  localparam state_t ST_WAIT_START = 3'd2;
  localparam state_t ST_MEASURE    = 3'd3;
  localparam state_t ST_CHECK      = 3'd4;
  localparam state_t ST_SET        = 3'd5;
  localparam state_t ST_LOCKED     = 3'd6;
  localparam state_t ST_ERROR      = 3'd7;

  // Divider loaded at reset: 32*(12+1) = 416 clk per bit.
  localparam logic [6:0] DEFAULT_DIV = 7'h0C;

  // Line must be high this many consecutive clocks before a start bit counts.
  localparam int unsigned WAIT_IDLE_LEN = 16;

  // 8 bit times / 256 = one bit time / 32; adding half of 256 rounds to nearest.
  localparam int unsigned ROUND_CONST = 128;
  localparam int unsigned ROUND_SHIFT = 8;

endpackage

// File: rtl/debug_rx_sync.sv
// -----------------------------------------------------------------------------
// debug_rx_sync
// Brings an asynchronous, idle-high serial line into the clk domain and
// produces a registered one-cycle pulse on every falling edge.
//   clk   in   system clock
//   rst   in   synchronous active-high reset (line forced to idle-high)
//   rx    in   asynchronous serial input
//   rx_s  out  synchronised line level
//   fall  out  1-cycle pulse, registered, one clock after rx_s goes low
// -----------------------------------------------------------------------------
module debug_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d   <= sync_q[SYNC_STAGES-1];
      // prev & ~cur, registered so downstream logic sees a clean flop output
      fall   <= rx_d & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debug_autobaud.sv
// -----------------------------------------------------------------------------
// debug_autobaud
// Measures a host-sent 0x55 sync byte on rx and derives the 7-bit divider for
// the debug baud generator (bit period = 32*(div+1) clk).
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   enable    in   level; rising edge arms a measurement, low aborts
//   rx        in   asynchronous serial input, idle high
//   baud_div  out  divider, held until the next successful lock
//   baud_set  out  1-cycle load strobe for the baud generator
//   busy      out  measurement in progress
//   locked    out  last measurement succeeded
//   err       out  last measurement failed
// -----------------------------------------------------------------------------
module debug_autobaud
  import debug_autobaud_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  output logic [6:0] baud_div,
  output logic       baud_set,
  output logic       busy,
  output logic       locked,
  output logic       err
);

  localparam int IW = CNT_W - 2;
  localparam logic [CNT_W-1:0] TOT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             enable_d;
  logic             rx_s;
  logic             fall;
  logic [4:0]       idle_cnt;
  logic [2:0]       edge_n;
  logic [CNT_W-1:0] total_cnt;
  logic [IW-1:0]    intv_cnt;
  logic [IW-1:0]    intv_inc;
  logic [IW-1:0]    intv_min;
  logic [IW-1:0]    intv_max;
  logic [CNT_W-1:0] quot;
  logic [CNT_W-1:0] div_calc;
  logic             arm;
  logic             idle_done;
  logic             tot_sat;
  logic             last_fall;
  logic             check_bad;

  function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Nearest-integer bit_time/32 from the 8-bit-time total; the sum is kept at
  // CNT_W bits on purpose.
  function automatic logic [CNT_W-1:0] round_quot(input logic [CNT_W-1:0] tot);
    logic [CNT_W-1:0] sum;
    sum = tot + CNT_W'(ROUND_CONST);
    return sum >> ROUND_SHIFT;
  endfunction

  debug_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rx_s(rx_s),
    .fall(fall)
  );

  assign arm       = enable & ~enable_d;
  assign idle_done = rx_s && (idle_cnt == 5'(WAIT_IDLE_LEN - 1));
  assign tot_sat   = (total_cnt == TOT_MAX - 1'b1);
  assign last_fall = fall && (edge_n == 3'd3);
  assign intv_inc  = sat_inc(intv_cnt);

  assign quot      = round_quot(total_cnt);
  assign div_calc  = quot - 1'b1;
  assign check_bad = (quot == '0)
                  || (div_calc > CNT_W'(127))
                  || ({2'b00, intv_max - intv_min} > (total_cnt >> 4));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; dropping enable in any busy state aborts to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (arm) state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE:  if (!enable) state_nxt = ST_IDLE;
                     else if (idle_done) state_nxt = ST_WAIT_START;
      ST_WAIT_START: if (!enable) state_nxt = ST_IDLE;
                     else if (fall) state_nxt = ST_MEASURE;
      // Saturation takes priority over a coincident fall.
      ST_MEASURE:    if (!enable) state_nxt = ST_IDLE;
                     else if (tot_sat) state_nxt = ST_ERROR;
                     else if (last_fall) state_nxt = ST_CHECK;
      ST_CHECK:      if (!enable) state_nxt = ST_IDLE;
                     else if (check_bad) state_nxt = ST_ERROR;
                     else state_nxt = ST_SET;
      ST_SET:        if (!enable) state_nxt = ST_IDLE;
                     else state_nxt = ST_LOCKED;
      ST_LOCKED,
      ST_ERROR:      if (!enable) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = 1'b0;
    baud_set = 1'b0;
    case (state)
      ST_WAIT_IDLE, ST_WAIT_START, ST_MEASURE, ST_CHECK: busy = 1'b1;
      ST_SET: begin
        busy     = 1'b1;
        baud_set = enable;
      end
      default: ;
    endcase
  end

  // Control registers: status flags, divider, idle and edge counters
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_d <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      baud_div <= DEFAULT_DIV;
      idle_cnt <= '0;
      edge_n   <= '0;
    end else begin
      enable_d <= enable;
      if (state == ST_IDLE && arm) begin
        locked <= 1'b0;
        err    <= 1'b0;
      end
      if (baud_set) begin
        baud_div <= div_calc[6:0];
        locked   <= 1'b1;
      end
      if (state_nxt == ST_ERROR && state != ST_ERROR) err <= 1'b1;

      // Counts consecutive high clocks; any low sample restarts the wait.
      if (state == ST_WAIT_IDLE && rx_s) idle_cnt <= idle_cnt + 5'd1;
      else                               idle_cnt <= '0;

      if (state == ST_WAIT_START)         edge_n <= '0;
      else if (state == ST_MEASURE && fall) edge_n <= edge_n + 3'd1;
    end
  end

  // Measurement datapath (not reset: always initialised in WAIT_START)
  always_ff @(posedge clk) begin
    if (state == ST_WAIT_START) begin
      total_cnt <= '0;
      intv_cnt  <= '0;
      intv_min  <= '1;
      intv_max  <= '0;
    end else if (state == ST_MEASURE) begin
      total_cnt <= (total_cnt == TOT_MAX) ? total_cnt : total_cnt + 1'b1;
      if (fall) begin
        // The captured value already includes the fall cycle, so the next
        // interval starts from zero and reaches 1 on the following clock.
        intv_cnt <= '0;
        if (intv_inc < intv_min) intv_min <= intv_inc;
        if (intv_inc > intv_max) intv_max <= intv_inc;
      end else begin
        intv_cnt <= intv_inc;
      end
    end
  end

endmodule

// File: tb/tb_debug_autobaud.sv
// -----------------------------------------------------------------------------
// tb_debug_autobaud
// Directed bench for debug_autobaud. Serial frames are described as bit-time
// level lists; a bit-time model derives lock/divider from the first five
// falling edges, and every clock the DUT baud_set/baud_div are compared with
// the expected strobe cycle and held divider.
// -----------------------------------------------------------------------------
module tb_debug_autobaud;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx;
  logic [6:0] baud_div;
  logic       baud_set;
  logic       busy;
  logic       locked;
  logic       err;

  always #5 clk = ~clk;

  debug_autobaud #(
    .CNT_W      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .rx      (rx),
    .baud_div(baud_div),
    .baud_set(baud_set),
    .busy    (busy),
    .locked  (locked),
    .err     (err)
  );

  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  int         nset   = 0;
  int         exp_set_cyc = -1;
  logic [6:0] div_before  = 7'h0C;
  logic [6:0] div_after   = 7'h0C;
  bit         chk_en = 1'b0;

  logic       lv [0:19];
  int         nlv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [6:0] cur_exp_div();
    return (exp_set_cyc >= 0 && cyc > exp_set_cyc) ? div_after : div_before;
  endfunction

  // One clock: sample 1 time unit after the rising edge and compare.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (baud_set === 1'b1) nset++;
    if (chk_en) begin
      check("baud_set", baud_set, cyc == exp_set_cyc);
      check("baud_div", baud_div, cur_exp_div());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // 8N1 frames, LSB first, one level per bit time.
  task automatic set_frames(input logic [7:0] b0, input logic [7:0] b1, input int nb);
    logic [7:0] b;
    nlv = 0;
    for (int f = 0; f < nb; f++) begin
      b = (f == 0) ? b0 : b1;
      lv[nlv] = 1'b0; nlv++;
      for (int k = 0; k < 8; k++) begin
        lv[nlv] = b[k]; nlv++;
      end
      lv[nlv] = 1'b1; nlv++;
    end
  endtask

  // Bit-time model: five falls span four intervals; divider is the rounded
  // bit period / 32 minus one; irregular interval spread or range -> error.
  function automatic void model(input int t_bit, output bit lock, output int div);
    int   f [5];
    int   nf;
    int   tot;
    int   mn;
    int   mx;
    int   iv;
    int   q;
    logic prev;
    nf   = 0;
    prev = 1'b1;
    lock = 1'b0;
    div  = 0;
    for (int i = 0; i < nlv; i++) begin
      if (prev && !lv[i] && nf < 5) begin
        f[nf] = i;
        nf++;
      end
      prev = lv[i];
    end
    if (nf < 5) return;
    tot = (f[4] - f[0]) * t_bit;
    mn  = 1 << 30;
    mx  = 0;
    for (int i = 0; i < 4; i++) begin
      iv = (f[i+1] - f[i]) * t_bit;
      if (iv < mn) mn = iv;
      if (iv > mx) mx = iv;
    end
    if (tot >= 65535) return;
    q    = ((tot + 128) % 65536) / 256;
    div  = q - 1;
    lock = (q != 0) && (div <= 127) && ((mx - mn) <= tot / 16);
  endfunction

  // Drive the level list; stop 16 clocks after fall number stop_fall.
  // A lock is expected SYNC_STAGES+3 clocks after the 5th fall hits the pin.
  task automatic run_levels(input int t_bit, input int stop_fall,
                            input bit exp_lock, input logic [6:0] exp_div);
    int   nf;
    logic prev;
    nf   = 0;
    prev = 1'b1;
    for (int i = 0; i < nlv; i++) begin
      rx = lv[i];
      if (prev && !lv[i]) begin
        nf++;
        if (nf == 5 && exp_lock) begin
          div_before  = cur_exp_div();
          div_after   = exp_div;
          exp_set_cyc = cyc + 5;
        end
      end
      prev = lv[i];
      if (nf == stop_fall) begin
        ticks(16);
        return;
      end
      ticks(t_bit);
    end
  endtask

  task automatic arm(input string name);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    ticks(20);
    check({name, " busy after arm"}, busy, 1);
    check({name, " locked cleared"}, locked, 0);
    check({name, " err cleared"}, err, 0);
  endtask

  task automatic do_txn(input string name, input logic [7:0] b0, input logic [7:0] b1,
                        input int nb, input int t_bit, input bit lit_lock,
                        input int lit_div, input int lit_bd);
    bit ml;
    int md;
    int n0;
    set_frames(b0, b1, nb);
    model(t_bit, ml, md);
    check({name, " model lock"}, ml, lit_lock);
    if (lit_lock) check({name, " model div"}, md, lit_div);
    n0 = nset;
    arm(name);
    run_levels(t_bit, 5, ml, md[6:0]);
    rx = 1'b1;
    ticks(40);
    check({name, " locked"}, locked, lit_lock);
    check({name, " err"}, err, !lit_lock);
    check({name, " busy"}, busy, 0);
    check({name, " baud_set count"}, nset - n0, lit_lock);
    check({name, " baud_div"}, baud_div, lit_bd);
  endtask

  initial begin
    int n0;
    rst    = 1'b1;
    enable = 1'b0;
    rx     = 1'b1;
    ticks(3);
    check("reset baud_div", baud_div, 7'h0C);
    check("reset baud_set", baud_set, 0);
    check("reset busy", busy, 0);
    check("reset locked", locked, 0);
    check("reset err", err, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    n0 = nset;
    ticks(1000);
    check("idle baud_set count", nset - n0, 0);

    do_txn("55@416",   8'h55, 8'h00, 1, 416,  1'b1, 12,  12);
    do_txn("55@32",    8'h55, 8'h00, 1, 32,   1'b1, 0,   0);
    do_txn("55@4096",  8'h55, 8'h00, 1, 4096, 1'b1, 127, 127);
    do_txn("55@4200",  8'h55, 8'h00, 1, 4200, 1'b0, 0,   127);
    do_txn("0F55@416", 8'h0F, 8'h55, 2, 416,  1'b0, 0,   127);

    // Abort after the second fall of a valid byte
    set_frames(8'h55, 8'h00, 1);
    n0 = nset;
    arm("abort");
    run_levels(416, 2, 1'b0, 7'h00);
    enable = 1'b0;
    tick();
    check("abort busy", busy, 0);
    check("abort locked", locked, 0);
    check("abort err", err, 0);
    rx = 1'b1;
    ticks(50);
    check("abort baud_set count", nset - n0, 0);
    do_txn("55@96", 8'h55, 8'h00, 1, 96, 1'b1, 2, 2);

    // Reset in the middle of a measurement
    set_frames(8'h55, 8'h00, 1);
    arm("rst");
    run_levels(416, 3, 1'b0, 7'h00);
    check("pre-rst busy", busy, 1);
    rst         = 1'b1;
    enable      = 1'b0;
    div_before  = 7'h0C;
    div_after   = 7'h0C;
    exp_set_cyc = -1;
    tick();
    check("rst baud_div", baud_div, 7'h0C);
    check("rst baud_set", baud_set, 0);
    check("rst busy", busy, 0);
    check("rst locked", locked, 0);
    check("rst err", err, 0);
    rst = 1'b0;
    rx  = 1'b0;
    tick();
    enable = 1'b1;
    ticks(100);
    check("rx low busy", busy, 1);
    check("rx low locked", locked, 0);
    check("rx low err", err, 0);
    enable = 1'b0;
    ticks(5);
    check("rx low abort busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
